// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite blitter
package sprite_pkg;

  localparam int SPRITE_SIZE = 16;
  localparam int COLOR_W     = 4;
  localparam int FB_ADDR_W   = 19;
  localparam int COORD_W     = 10;

  localparam logic [COLOR_W-1:0] DEFAULT_TRANSPARENT = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sprite_pix_gen.sv
// rtl/sprite_pix_gen.sv - raster pixel walker with scaling, clipping and address generation
module sprite_pix_gen
  import sprite_pkg::*;
#(
  parameter int                 FB_WIDTH    = 640,
  parameter int                 FB_HEIGHT   = 480,
  parameter int                 SCALE_LOG2  = 0,
  parameter logic [COLOR_W-1:0] TRANSPARENT = DEFAULT_TRANSPARENT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 advance,
  input  logic [COORD_W-1:0]   dest_x,
  input  logic [COORD_W-1:0]   dest_y,
  input  logic [COLOR_W-1:0]   color,
  output logic [COORD_W-1:0]   rom_x,
  output logic [COORD_W-1:0]   rom_y,
  output logic                 pixel_valid,
  output logic                 last,
  output logic                 clip,
  output logic [FB_ADDR_W-1:0] addr
);

  // Footprint is at most 128 pixels wide, so 7-bit counters suffice.
  localparam int             FOOT = SPRITE_SIZE << SCALE_LOG2;
  localparam int             CW   = 7;
  localparam logic [CW-1:0]  PMAX = CW'(FOOT - 1);

  logic [CW-1:0]      px, py;
  logic [COORD_W-1:0] dx_q, dy_q;
  logic [10:0]        sx, sy;

  // Capture destination on load, then walk px/py in raster order on each advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      px   <= '0;
      py   <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else if (load) begin
      px   <= '0;
      py   <= '0;
      dx_q <= dest_x;
      dy_q <= dest_y;
    end else if (advance) begin
      if (px == PMAX) begin
        px <= '0;
        py <= (py == PMAX) ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  // Screen position at 11 bits so the clip compare never sees a wrapped sum.
  always_comb begin
    rom_x       = COORD_W'(px >> SCALE_LOG2);
    rom_y       = COORD_W'(py >> SCALE_LOG2);
    sx          = 11'(dx_q) + 11'(px);
    sy          = 11'(dy_q) + 11'(py);
    clip        = (sx >= 11'(FB_WIDTH)) || (sy >= 11'(FB_HEIGHT));
    pixel_valid = !clip && (color != TRANSPARENT);
    last        = (px == PMAX) && (py == PMAX);
    addr        = clip ? '0 : FB_ADDR_W'(sy) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(sx);
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies a 16x16 sprite from ROM into the framebuffer write port
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int                 FB_WIDTH    = 640,
  parameter int                 FB_HEIGHT   = 480,
  parameter int                 SCALE_LOG2  = 0,
  parameter logic [COLOR_W-1:0] TRANSPARENT = DEFAULT_TRANSPARENT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COORD_W-1:0]   dest_x,
  input  logic [COORD_W-1:0]   dest_y,
  output logic                 busy,
  output logic                 done,
  output logic [COORD_W-1:0]   rom_x,
  output logic [COORD_W-1:0]   rom_y,
  input  logic [7:0]           rom_data,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  input  logic                 fb_ready
);

  state_t               state, state_next;
  logic                 accept_start;
  logic                 out_free;
  logic                 consume;
  logic                 pixel_valid;
  logic                 last;
  logic                 clip;
  logic [FB_ADDR_W-1:0] pix_addr;
  logic [COLOR_W-1:0]   color;
  logic                 unused_rom_hi;

  // Upper ROM nibble carries no colour information.
  assign color         = rom_data[COLOR_W-1:0];
  assign unused_rom_hi = ^rom_data[7:COLOR_W];

  // The output slot can take a new pixel when empty or being drained this cycle.
  assign out_free     = !fb_we || fb_ready;
  assign accept_start = (state == IDLE) && start;
  assign consume      = (state == RUN) && out_free;

  sprite_pix_gen #(
    .FB_WIDTH    (FB_WIDTH),
    .FB_HEIGHT   (FB_HEIGHT),
    .SCALE_LOG2  (SCALE_LOG2),
    .TRANSPARENT (TRANSPARENT)
  ) u_pix_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (accept_start),
    .advance     (consume),
    .dest_x      (dest_x),
    .dest_y      (dest_y),
    .color       (color),
    .rom_x       (rom_x),
    .rom_y       (rom_y),
    .pixel_valid (pixel_valid),
    .last        (last),
    .clip        (clip),
    .addr        (pix_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN walks every pixel, DRAIN waits for the last write to leave.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (consume && last) state_next = DRAIN;
      DRAIN:   if (out_free) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Single-entry write register: loads on consume, holds until the arbiter accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (consume) begin
      fb_we <= pixel_valid;
      if (pixel_valid) begin
        fb_addr <= pix_addr;
        fb_data <= color;
      end
    end else if (fb_ready) begin
      fb_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        fb_ready = 1'b1;
  logic [9:0]  dest_x = '0;
  logic [9:0]  dest_y = '0;

  logic        busy1, done1, fb_we1, busy2, done2, fb_we2;
  logic [9:0]  rom_x1, rom_y1, rom_x2, rom_y2;
  logic [7:0]  rom_data1, rom_data2;
  logic [18:0] fb_addr1, fb_addr2;
  logic [3:0]  fb_data1, fb_data2;

  int rom_mode = 0;
  int sel = 0;
  int bp_en = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_val(input int mode, input int x, input int y);
    if (mode == 0) return 4'h5;
    if (mode == 1) return ((x + y) % 2 == 1) ? 4'h9 : 4'h0;
    return 4'((x + y) % 15 + 1);
  endfunction

  assign rom_data1 = {4'hA, rom_val(rom_mode, int'(rom_x1), int'(rom_y1))};
  assign rom_data2 = {4'hA, rom_val(rom_mode, int'(rom_x2), int'(rom_y2))};

  sprite_blitter #(.FB_WIDTH(640), .FB_HEIGHT(480), .SCALE_LOG2(0), .TRANSPARENT(4'h0)) u_dut (
    .clk(clk), .reset(reset), .start(start1), .dest_x(dest_x), .dest_y(dest_y),
    .busy(busy1), .done(done1), .rom_x(rom_x1), .rom_y(rom_y1), .rom_data(rom_data1),
    .fb_we(fb_we1), .fb_addr(fb_addr1), .fb_data(fb_data1), .fb_ready(fb_ready)
  );

  sprite_blitter #(.FB_WIDTH(640), .FB_HEIGHT(480), .SCALE_LOG2(1), .TRANSPARENT(4'h0)) u_dut_x2 (
    .clk(clk), .reset(reset), .start(start2), .dest_x(dest_x), .dest_y(dest_y),
    .busy(busy2), .done(done2), .rom_x(rom_x2), .rom_y(rom_y2), .rom_data(rom_data2),
    .fb_we(fb_we2), .fb_addr(fb_addr2), .fb_data(fb_data2), .fb_ready(fb_ready)
  );

  logic        m_we, m_done, m_busy;
  logic [18:0] m_addr;
  logic [3:0]  m_data;
  assign m_we   = (sel == 1) ? fb_we2   : fb_we1;
  assign m_done = (sel == 1) ? done2    : done1;
  assign m_busy = (sel == 1) ? busy2    : busy1;
  assign m_addr = (sel == 1) ? fb_addr2 : fb_addr1;
  assign m_data = (sel == 1) ? fb_data2 : fb_data1;

  // Cycle counter and fb_ready pattern (1,0,0,1 repeating when backpressure is on)
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    fb_ready = (bp_en == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
  end

  logic [18:0] wa[$];
  logic [3:0]  wd[$];
  int first_we, last_we, done_cyc, ndone, busy_at_done, stall_err;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_a;
  logic [3:0]  prev_d;

  // Monitor: records accepted writes, done pulses and stall stability
  always @(negedge clk) begin
    if (prev_stall && (m_we !== 1'b1 || m_addr !== prev_a || m_data !== prev_d)) stall_err++;
    prev_stall = m_we && !fb_ready;
    prev_a = m_addr;
    prev_d = m_data;
    if (m_we === 1'b1 && fb_ready) begin
      wa.push_back(m_addr);
      wd.push_back(m_data);
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    if (m_done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
      busy_at_done = int'(m_busy);
    end
  end

  task automatic mon_clear();
    wa.delete();
    wd.delete();
    first_we = -1;
    last_we = -1;
    done_cyc = -1;
    ndone = 0;
    busy_at_done = -1;
    stall_err = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_start(input int which, input int dx, input int dy, output int t0);
    @(posedge clk);
    #1;
    dest_x = 10'(dx);
    dest_y = 10'(dy);
    if (which == 1) start2 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && ndone == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  function automatic int seq_err(input int dx, input int dy, input int sh, input int mode);
    int foot = 16 << sh;
    int k = 0;
    int err = 0;
    for (int py = 0; py < foot; py++) begin
      for (int px = 0; px < foot; px++) begin
        int sx = dx + px;
        int sy = dy + py;
        logic [3:0] c = rom_val(mode, px >> sh, py >> sh);
        if (c != 4'h0 && sx < 640 && sy < 480) begin
          if (k >= wa.size()) err++;
          else if (wa[k] !== 19'(sy * 640 + sx) || wd[k] !== c) err++;
          k++;
        end
      end
    end
    if (k != wa.size()) err++;
    return err;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
    n_checks++; if (fb_we1 !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b expected 0", fb_we1); end
    n_checks++; if (fb_addr1 !== 19'd0 || fb_data1 !== 4'd0) begin n_fail++; $display("FAIL reset_fb_regs: got addr %0d data %0d expected 0 0", fb_addr1, fb_data1); end
    n_checks++; if (rom_x1 !== 10'd0 || rom_y1 !== 10'd0) begin n_fail++; $display("FAIL reset_rom_xy: got %0d,%0d expected 0,0", rom_x1, rom_y1); end
    n_checks++; if (busy2 !== 1'b0 || fb_we2 !== 1'b0) begin n_fail++; $display("FAIL reset_x2: got busy %b we %b expected 0 0", busy2, fb_we2); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_opaque();
    int t0;
    sel = 0; rom_mode = 0; mon_clear();
    do_start(0, 0, 0, t0);
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL opaque_busy_t1: got %b expected 1", busy1); end
    wait_done();
    n_checks++; if (wa.size() != 256) begin n_fail++; $display("FAIL opaque_count: got %0d expected 256", wa.size()); end
    n_checks++; if (first_we != t0 + 2) begin n_fail++; $display("FAIL opaque_first_we: got %0d expected %0d", first_we - t0, 2); end
    n_checks++; if (last_we != t0 + 257) begin n_fail++; $display("FAIL opaque_last_we: got %0d expected %0d", last_we - t0, 257); end
    n_checks++; if (done_cyc != t0 + 258) begin n_fail++; $display("FAIL opaque_done_cyc: got %0d expected %0d", done_cyc - t0, 258); end
    n_checks++; if (busy_at_done != 0) begin n_fail++; $display("FAIL opaque_busy_at_done: got %0d expected 0", busy_at_done); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL opaque_done_pulses: got %0d expected 1", ndone); end
    n_checks++; if (seq_err(0, 0, 0, 0) != 0) begin n_fail++; $display("FAIL opaque_sequence: got %0d errors expected 0", seq_err(0, 0, 0, 0)); end
  endtask

  task automatic test_checker();
    int t0;
    int bad = 0;
    sel = 0; rom_mode = 1; mon_clear();
    do_start(0, 0, 0, t0);
    wait_done();
    foreach (wa[i]) if (((int'(wa[i]) % 640) + (int'(wa[i]) / 640)) % 2 != 1 || wd[i] !== 4'h9) bad++;
    n_checks++; if (wa.size() != 128) begin n_fail++; $display("FAIL checker_count: got %0d expected 128", wa.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL checker_parity: got %0d bad writes expected 0", bad); end
    n_checks++; if (done_cyc != t0 + 258) begin n_fail++; $display("FAIL checker_done_cyc: got %0d expected %0d", done_cyc - t0, 258); end
    n_checks++; if (seq_err(0, 0, 0, 1) != 0) begin n_fail++; $display("FAIL checker_sequence: got %0d errors expected 0", seq_err(0, 0, 0, 1)); end
  endtask

  task automatic test_clip();
    int t0;
    int maxa = 0;
    sel = 0; rom_mode = 0; mon_clear();
    do_start(0, 630, 470, t0);
    wait_done();
    foreach (wa[i]) if (int'(wa[i]) > maxa) maxa = int'(wa[i]);
    n_checks++; if (wa.size() != 100) begin n_fail++; $display("FAIL clip_count: got %0d expected 100", wa.size()); end
    n_checks++; if (maxa >= 307200) begin n_fail++; $display("FAIL clip_max_addr: got %0d expected < 307200", maxa); end
    n_checks++; if (seq_err(630, 470, 0, 0) != 0) begin n_fail++; $display("FAIL clip_sequence: got %0d errors expected 0", seq_err(630, 470, 0, 0)); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL clip_done_pulses: got %0d expected 1", ndone); end
  endtask

  task automatic test_backpressure();
    int t0;
    sel = 0; rom_mode = 0; mon_clear();
    bp_en = 1;
    do_start(0, 0, 0, t0);
    wait_done();
    bp_en = 0;
    n_checks++; if (wa.size() != 256) begin n_fail++; $display("FAIL bp_count: got %0d expected 256", wa.size()); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
    n_checks++; if (seq_err(0, 0, 0, 0) != 0) begin n_fail++; $display("FAIL bp_sequence: got %0d errors expected 0", seq_err(0, 0, 0, 0)); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", ndone); end
  endtask

  task automatic test_scale();
    int t0;
    sel = 1; rom_mode = 2; mon_clear();
    do_start(1, 100, 100, t0);
    wait_done();
    n_checks++; if (wa.size() != 1024) begin n_fail++; $display("FAIL scale_count: got %0d expected 1024", wa.size()); end
    n_checks++; if (seq_err(100, 100, 1, 2) != 0) begin n_fail++; $display("FAIL scale_sequence: got %0d errors expected 0", seq_err(100, 100, 1, 2)); end
    n_checks++; if (done_cyc != t0 + 1026) begin n_fail++; $display("FAIL scale_done_cyc: got %0d expected %0d", done_cyc - t0, 1026); end
    sel = 0;
  endtask

  task automatic test_reset_abort();
    int t0;
    sel = 0; rom_mode = 0; mon_clear();
    do_start(0, 0, 0, t0);
    for (int i = 0; i < 500 && wa.size() < 40; i++) @(negedge clk);
    n_checks++; if (wa.size() != 40) begin n_fail++; $display("FAIL abort_reach_40: got %0d expected 40", wa.size()); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (fb_we1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_after_reset: got we %b busy %b expected 0 0", fb_we1, busy1); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    mon_clear();
    do_start(0, 200, 0, t0);
    wait_done();
    n_checks++; if (wa.size() != 256) begin n_fail++; $display("FAIL abort_redraw_count: got %0d expected 256", wa.size()); end
    n_checks++; if (seq_err(200, 0, 0, 0) != 0) begin n_fail++; $display("FAIL abort_redraw_sequence: got %0d errors expected 0", seq_err(200, 0, 0, 0)); end
    n_checks++; if (ndone != 1 || done_cyc != t0 + 258) begin n_fail++; $display("FAIL abort_redraw_done: got %0d pulses at +%0d expected 1 at +258", ndone, done_cyc - t0); end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_opaque();
    test_checker();
    test_clip();
    test_backpressure();
    test_scale();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
